// File: rtl/spike_event_encoder.sv
// Converts a spike vector into a stream of {timestep, neuron_id} event words,
// lowest neuron first, honouring backpressure from the downstream FIFO.
module spike_event_encoder #(
    parameter int unsigned NUM_NEURONS = 64,
    parameter int unsigned TS_WIDTH    = 8,
    parameter int unsigned ID_WIDTH    = $clog2(NUM_NEURONS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         spike_valid,
    output logic                         spike_ready,
    input  logic [NUM_NEURONS-1:0]       spike_vec,
    input  logic [TS_WIDTH-1:0]          timestep,
    output logic                         fifo_wr_en,
    output logic [TS_WIDTH+ID_WIDTH-1:0] fifo_wr_data,
    input  logic                         fifo_full,
    output logic                         busy,
    output logic                         frame_done,
    output logic [ID_WIDTH:0]            frame_event_count,
    output logic [31:0]                  total_event_count
);

    localparam int unsigned CNT_W   = ID_WIDTH + 1;
    localparam int unsigned TOTAL_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [NUM_NEURONS-1:0] pending;
    logic [NUM_NEURONS-1:0] pending_clr;
    logic [TS_WIDTH-1:0]    ts_q;
    logic [ID_WIDTH-1:0]    idx;
    logic [CNT_W-1:0]       frame_cnt;

    // Priority encoder: descending scan so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                idx = ID_WIDTH'(i);
            end
        end
    end

    // Clearing the lowest set bit is the same bit idx points at.
    assign pending_clr  = pending & (pending - NUM_NEURONS'(1));
    assign fifo_wr_en   = (state == SCAN) && (pending != '0) && !fifo_full && !rst;
    assign fifo_wr_data = {ts_q, idx};

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            pending           <= '0;
            ts_q              <= '0;
            frame_cnt         <= '0;
            frame_event_count <= '0;
            total_event_count <= '0;
            spike_ready       <= 1'b1;
            busy              <= 1'b0;
            frame_done        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (fifo_wr_en && (total_event_count != '1)) begin
                total_event_count <= total_event_count + TOTAL_W'(1);
            end
            case (state)
                IDLE: begin
                    if (spike_valid) begin
                        pending     <= spike_vec;
                        ts_q        <= timestep;
                        frame_cnt   <= '0;
                        spike_ready <= 1'b0;
                        busy        <= 1'b1;
                        if (spike_vec != '0) begin
                            state <= SCAN;
                        end else begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    // A full FIFO suppresses fifo_wr_en, which freezes everything here.
                    if (fifo_wr_en) begin
                        pending   <= pending_clr;
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        if (pending_clr == '0) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    frame_event_count <= frame_cnt;
                    state             <= IDLE;
                    spike_ready       <= 1'b1;
                    busy              <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    spike_ready <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder; a negedge monitor checks every FIFO write
// against a scoreboard queue filled when each vector is driven.
module tb_spike_event_encoder;

    localparam int unsigned NN  = 64;
    localparam int unsigned TSW = 8;
    localparam int unsigned IDW = 6;
    localparam int unsigned WW  = TSW + IDW;

    logic           clk = 1'b0;
    logic           rst;
    logic           spike_valid;
    logic           spike_ready;
    logic [NN-1:0]  spike_vec;
    logic [TSW-1:0] timestep;
    logic           fifo_wr_en;
    logic [WW-1:0]  fifo_wr_data;
    logic           fifo_full;
    logic           busy;
    logic           frame_done;
    logic [IDW:0]   frame_event_count;
    logic [31:0]    total_event_count;

    int checks   = 0;
    int passed   = 0;
    int failed   = 0;
    int done_cnt = 0;
    logic [WW-1:0] sb[$];
    logic [WW-1:0] exp_word;

    spike_event_encoder dut (
        .clk               (clk),
        .rst               (rst),
        .spike_valid       (spike_valid),
        .spike_ready       (spike_ready),
        .spike_vec         (spike_vec),
        .timestep          (timestep),
        .fifo_wr_en        (fifo_wr_en),
        .fifo_wr_data      (fifo_wr_data),
        .fifo_full         (fifo_full),
        .busy              (busy),
        .frame_done        (frame_done),
        .frame_event_count (frame_event_count),
        .total_event_count (total_event_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample point of the current cycle.
    task automatic smp();
        @(negedge clk);
    endtask

    // Drive point of the next cycle.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [NN-1:0] v, input logic [TSW-1:0] ts);
        for (int i = 0; i < int'(NN); i++) begin
            if (v[i]) sb.push_back({ts, IDW'(i)});
        end
    endtask

    // Presents a vector for one edge (accept edge N); returns at cycle N+1 drive point.
    task automatic send(input logic [NN-1:0] v, input logic [TSW-1:0] ts, input bit hold);
        spike_valid = 1'b1;
        spike_vec   = v;
        timestep    = ts;
        @(posedge clk);
        #1;
        if (!hold) spike_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (fifo_wr_en === 1'b1) begin
            chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                exp_word = sb.pop_front();
                chk("wr_data", 64'(fifo_wr_data), 64'(exp_word));
            end
        end
    end

    initial begin
        rst         = 1'b1;
        spike_valid = 1'b0;
        spike_vec   = '0;
        timestep    = '0;
        fifo_full   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        smp();
        chk("rst_ready", 64'(spike_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_wr_data", 64'(fifo_wr_data), 64'd0);
        chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        chk("rst_total", 64'(total_event_count), 64'd0);
        chk("rst_fec", 64'(frame_event_count), 64'd0);
        adv();

        // Three spikes, no backpressure
        push_frame(64'h91, 8'd5);
        send(64'h91, 8'd5, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            smp();
            chk("t1_wr_en", 64'(fifo_wr_en), 64'd1);
            chk("t1_no_done", 64'(frame_done), 64'd0);
            adv();
        end
        smp();
        chk("t1_done", 64'(frame_done), 64'd1);
        chk("t1_done_wr_en", 64'(fifo_wr_en), 64'd0);
        chk("t1_done_busy", 64'(busy), 64'd1);
        adv();
        smp();
        chk("t1_ready", 64'(spike_ready), 64'd1);
        chk("t1_done_pulse", 64'(frame_done), 64'd0);
        chk("t1_fec", 64'(frame_event_count), 64'd3);
        adv();

        // Same vector with FIFO full in cycles N+2..N+5
        push_frame(64'h91, 8'd5);
        send(64'h91, 8'd5, 1'b0);
        smp();
        chk("t2_first_wr", 64'(fifo_wr_en), 64'd1);
        adv();
        fifo_full = 1'b1;
        for (int c = 2; c <= 5; c++) begin
            smp();
            chk("t2_full_no_wr", 64'(fifo_wr_en), 64'd0);
            chk("t2_full_busy", 64'(busy), 64'd1);
            adv();
        end
        fifo_full = 1'b0;
        for (int c = 6; c <= 7; c++) begin
            smp();
            chk("t2_resume_wr", 64'(fifo_wr_en), 64'd1);
            adv();
        end
        smp();
        chk("t2_done", 64'(frame_done), 64'd1);
        adv();
        smp();
        chk("t2_fec", 64'(frame_event_count), 64'd3);
        adv();

        // Empty vector
        send(64'h0, 8'd9, 1'b0);
        smp();
        chk("t3_done", 64'(frame_done), 64'd1);
        chk("t3_no_wr", 64'(fifo_wr_en), 64'd0);
        adv();
        smp();
        chk("t3_ready", 64'(spike_ready), 64'd1);
        chk("t3_fec", 64'(frame_event_count), 64'd0);
        adv();

        // All ones with spike_valid held high
        push_frame({NN{1'b1}}, 8'hA5);
        send({NN{1'b1}}, 8'hA5, 1'b1);
        for (int c = 1; c <= 64; c++) begin
            smp();
            chk("t4_wr_en", 64'(fifo_wr_en), 64'd1);
            chk("t4_not_ready", 64'(spike_ready), 64'd0);
            adv();
        end
        smp();
        chk("t4_done", 64'(frame_done), 64'd1);
        chk("t4_done_not_ready", 64'(spike_ready), 64'd0);
        adv();
        smp();
        chk("t4_ready", 64'(spike_ready), 64'd1);
        chk("t4_fec", 64'(frame_event_count), 64'd64);
        chk("t4_total", 64'(total_event_count), 64'd70);
        spike_valid = 1'b0;
        adv();

        // Reset in cycle N+2 of a three-spike frame
        sb.push_back({8'd3, 6'd0});
        send(64'h91, 8'd3, 1'b0);
        smp();
        chk("t5_first_wr", 64'(fifo_wr_en), 64'd1);
        adv();
        rst = 1'b1;
        smp();
        chk("t5_rst_no_wr", 64'(fifo_wr_en), 64'd0);
        adv();
        rst = 1'b0;
        smp();
        chk("t5_ready", 64'(spike_ready), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_no_done", 64'(frame_done), 64'd0);
        chk("t5_total", 64'(total_event_count), 64'd0);
        chk("t5_wr_data", 64'(fifo_wr_data), 64'd0);
        adv();
        repeat (3) adv();
        smp();
        chk("t5_no_wr_after", 64'(fifo_wr_en), 64'd0);
        adv();

        // Saturation of total_event_count
        force dut.total_event_count = 32'hFFFF_FFFE;
        adv();
        release dut.total_event_count;
        push_frame(64'h91, 8'd7);
        send(64'h91, 8'd7, 1'b0);
        repeat (5) adv();
        smp();
        chk("t6_total_sat", 64'(total_event_count), 64'hFFFF_FFFF);
        chk("t6_fec", 64'(frame_event_count), 64'd3);
        adv();

        repeat (2) adv();
        smp();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("done_pulses", 64'(done_cnt), 64'd5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/spike_event_encoder.md
SPIKE_EVENT_ENCODER -- requirements
Module: spike_event_encoder

Interface
REQ-001 Parameter NUM_NEURONS, default 64: width of the spike vector from the neuron array.
REQ-002 Parameter TS_WIDTH, default 8: width of the timestep tag.
REQ-003 Parameter ID_WIDTH, default $clog2(NUM_NEURONS): width of the neuron index.
REQ-004 Port clk  input  1  system clock; all logic is on the rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port spike_valid  input  1  spike_vec and timestep are valid.
REQ-007 Port spike_ready  output  1  block can accept a new vector.
REQ-008 Port spike_vec  input  NUM_NEURONS  one bit per neuron; 1 means the neuron fired.
REQ-009 Port timestep  input  TS_WIDTH  timestep tag for the vector.
REQ-010 Port fifo_wr_en  output  1  write strobe to the downstream event FIFO.
REQ-011 Port fifo_wr_data  output  TS_WIDTH+ID_WIDTH  event word {timestep, neuron_id}.
REQ-012 Port fifo_full  input  1  full flag from the downstream FIFO.
REQ-013 Port busy  output  1  high in every state except IDLE.
REQ-014 Port frame_done  output  1  one-cycle pulse after a vector is fully drained.
REQ-015 Port frame_event_count  output  ID_WIDTH+1  number of events emitted for the last completed vector.
REQ-016 Port total_event_count  output  32  total events emitted since reset; saturates.

Function
REQ-017 The block SHALL implement three states: IDLE, SCAN and DONE.
REQ-018 spike_ready SHALL be 1 in IDLE only.
REQ-019 An accept SHALL be spike_valid && spike_ready at a clock edge.
REQ-020 On accept, the block SHALL latch spike_vec into register pending and timestep into register ts_q.
REQ-021 On accept, the next state SHALL be SCAN if spike_vec != 0, and DONE if spike_vec == 0.
REQ-022 In SCAN, fifo_wr_en SHALL be combinational: (pending != 0) && !fifo_full && !rst.
REQ-023 In SCAN, fifo_wr_data SHALL be {ts_q, idx}, where idx is the index of the lowest set bit of pending (priority encoder).
REQ-024 On each edge where fifo_wr_en = 1, the block SHALL clear bit idx of pending and increment the frame counter.
REQ-025 While fifo_full = 1, the block SHALL hold pending, idx and state unchanged and keep fifo_wr_en at 0, so the FIFO never overflows.
REQ-026 SCAN SHALL go to DONE on the edge that writes the last set bit; the first write SHALL occur in the cycle after accept.
REQ-027 In DONE, the block SHALL assert frame_done for exactly one cycle, load frame_event_count from the frame counter, and go to IDLE.
REQ-028 Latency with no backpressure: accept at edge N, k spikes → writes in cycles N+1..N+k, frame_done in cycle N+k+1, spike_ready again in cycle N+k+2.
REQ-029 With an empty vector (k = 0), frame_done SHALL assert in cycle N+1 with frame_event_count = 0.
REQ-030 The frame counter SHALL clear on accept; its width SHALL hold NUM_NEURONS (all bits set).
REQ-031 total_event_count SHALL increment on every fifo_wr_en and SHALL saturate at 0xFFFFFFFF without wrap-around.
REQ-032 spike_valid asserted outside IDLE SHALL be ignored; the input vector is not consumed.
REQ-033 fifo_wr_en SHALL be 0 in IDLE and DONE.

Reset
REQ-034 While rst = 1, on the next edge: state = IDLE, pending = 0, ts_q = 0, frame counter = 0, frame_event_count = 0, total_event_count = 0.
REQ-035 rst = 1 mid-SCAN SHALL abort the frame; fifo_wr_en SHALL be 0 in the reset cycle itself, and no frame_done SHALL be issued.
REQ-036 After rst is released, outputs SHALL be: spike_ready = 1, busy = 0, frame_done = 0, fifo_wr_data = 0.

Verification
REQ-037 Vector 0x...0000_0091 (bits 0, 4, 7), timestep = 5, fifo_full = 0 → writes {5,0}, {5,4}, {5,7} in cycles N+1..N+3; frame_done in cycle N+4; frame_event_count = 3.
REQ-038 Same vector, fifo_full = 1 during cycles N+2..N+5 → {5,4} is written in cycle N+6 with no lost or duplicate event; fifo_wr_en = 0 while full.
REQ-039 All-zero vector → no writes; frame_done in cycle N+1; frame_event_count = 0.
REQ-040 All-ones vector (64 spikes) → 64 writes with ids 0..63 ascending; frame_event_count = 64; spike_valid held high throughout is not re-accepted until IDLE.
REQ-041 rst pulsed in cycle N+2 of a 3-spike frame → one event written, no frame_done, total_event_count = 0, spike_ready = 1 after release.
REQ-042 Preload total_event_count to 0xFFFFFFFE (force), then a 3-spike frame → total_event_count = 0xFFFFFFFF, with no wrap to 0.
